seg7_scan: RTL and testbench
============================

// Module: seg7_scan
// PURPOSE
//  Parametrised memory-mapped multiplexed 7-segment driver; successor to the fixed 4-digit hex driver.
//  Sits on the CPU data bus at BASE; drives NDIGITS common-anode digits through active-low seg/an.
//  Adds a synchronous reset, register readback, per-digit blanking, 16-level PWM brightness and raw-segment mode.
// PARAMETERS
//  NDIGITS   4     number of digits (1..8); register block SIZE = 3 + NDIGITS words
//  BASE      16    word address of register 0
//  SCAN_DIV  1024  clk cycles per subtick (>=2); one digit slot = 16 subticks
// PORTS
//  clk      in   1          single clock, all state on posedge
//  reset_n  in   1          synchronous, active-low reset
//  enable   in   1          bus strobe
//  rw       in   1          1 = write, 0 = read
//  addr     in   32         word address
//  data     in   32         write data
//  q        out  32         read data, registered
//  seg      out  8          active-low segments: [0]=a..[6]=g, [7]=dp
//  an       out  NDIGITS    active-low digit anodes
// BEHAVIOUR
//  Register map (offset = addr - BASE; in range iff BASE <= addr < BASE + SIZE):
//   0 DIGITS  [4*NDIGITS-1:0] hex nibble per digit, digit i = bits [4i+3:4i]
//   1 DP      [NDIGITS-1:0] 1 = decimal point lit
//   2 CTRL    [NDIGITS-1:0] blank mask (1 = dark); [NDIGITS+3:NDIGITS] bright; [NDIGITS+4] raw
//   3+i RAW_i [7:0] active-high segment pattern for digit i (bit 7 = dp); used only when raw=1
//  Reset (reset_n=0 at posedge): registers 0 except CTRL.bright=15; q=0; seg=8'hFF; an=all 1; counters 0.
//  Write: enable & rw & in range & reset_n -> register updated at that edge; unused upper bits dropped.
//  Read: enable & ~rw & in range -> q = zero-extended register at next edge; out-of-range read -> q=0;
//   q holds otherwise. Read of a register written the same cycle returns the old value.
//  Out-of-range or enable=0 accesses: no state change.
//  Scan: prescaler 0..SCAN_DIV-1; terminal count = tick. Subtick 0..15 advances on tick;
//   subtick 15->0 advances digit 0..NDIGITS-1, wrapping NDIGITS-1 -> 0.
//  Anode for current digit d active iff ~blank[d] & 1 <= subtick <= bright; subtick 0 is always dark
//   (anti-ghosting); bright=0 -> display dark; bright=15 -> 15/16 duty. Only one an bit low at a time.
//  Segments: raw=0 -> ~{dp[d], font(nibble d)}; raw=1 -> ~RAW_d. Hex font: standard 0-9, A,b,C,d,E,F.
//  seg and an are registered: reflect counter and register state of the previous cycle (1-cycle latency).
//  A register write becomes visible on seg/an the second edge after the write edge; CTRL changes act mid-slot.
//  Reset mid-scan: outputs dark at next edge; scan restarts at digit 0, subtick 0.
// STRUCTURE
//  seg7_pkg: register offsets (REG_DIGITS/REG_DP/REG_CTRL/REG_RAW0), CTRL field positions,
//   SUBTICKS=16, function hex2seg(4b)->7b active-high font.
//  Sub-module seg7_prescale: counter with SCAN_DIV parameter, reset_n, tick output.
//  Top: register file, read mux, subtick/digit counters, output registers.
// TESTING (NDIGITS=4, BASE=16, SCAN_DIV=2 unless stated)
//  Reset: hold reset_n=0 3 cycles -> seg=8'hFF, an=4'hF, q=0; read CTRL -> q=32'h0000_00F0.
//  Write DIGITS=0x1208, DP=0x1 -> per slot: digit0 an=4'hE seg=8'h00; digit1 an=4'hD seg=8'hC0;
//   digit2 an=4'hB seg=8'hA4; digit3 an=4'h7 seg=8'hF9; order 0,1,2,3,0.
//  CTRL bright=3 -> each an bit low exactly 3 of 16 subticks (6 clks), high at subtick 0; bright=0 -> an=4'hF always.
//  CTRL blank=4'b0100 -> an[2] never low; other digits unchanged; slot timing unchanged.
//  CTRL raw=1, RAW_1=0x76 -> digit1 seg=8'h89; DIGITS ignored.
//  Write addr 23 (out of range) with data 0xFFFF_FFFF -> all registers unchanged, read addr 23 -> q=0;
//   reset_n pulsed mid-slot -> an=4'hF next edge, scan resumes at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// register offsets, CTRL field placement and the hex font.
package seg7_pkg;

  // Register offsets relative to BASE
  localparam logic [31:0] REG_DIGITS = 32'd0;
  localparam logic [31:0] REG_DP     = 32'd1;
  localparam logic [31:0] REG_CTRL   = 32'd2;
  localparam logic [31:0] REG_RAW0   = 32'd3;

  // CTRL layout: blank mask occupies [NDIGITS-1:0]; the fields below are
  // positioned relative to NDIGITS (bit index = NDIGITS + position)
  localparam int CTRL_BRIGHT_POS = 0;
  localparam int CTRL_BRIGHT_W   = 4;
  localparam int CTRL_RAW_POS    = 4;

  // Subticks per digit slot; also the number of brightness levels
  localparam int SUBTICKS = 16;

  // Active-high font, bit 0 = segment a .. bit 6 = segment g
  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    logic [6:0] pattern;
    pattern = 7'h00;
    case (nibble)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      4'hF: pattern = 7'h71;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_prescale.sv
// Free-running prescaler that divides clk down to the subtick rate.
// tick is high during the last count of each period.
module seg7_prescale #(
  parameter int SCAN_DIV = 1024
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // Count 0..SCAN_DIV-1 and wrap, restarting from zero on reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Memory-mapped multiplexed 7-segment driver for NDIGITS common-anode
// digits with readback, blanking, 16-level PWM brightness and raw mode.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int BASE     = 16,
  parameter int SCAN_DIV = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               rw,
  input  logic [31:0]        addr,
  input  logic [31:0]        data,
  output logic [31:0]        q,
  output logic [7:0]         seg,
  output logic [NDIGITS-1:0] an
);

  localparam int SIZE  = 3 + NDIGITS;
  localparam int DIG_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NDIGITS - 1);

  logic [4*NDIGITS-1:0] digits;
  logic [NDIGITS-1:0]   dp;
  logic [NDIGITS-1:0]   blank;
  logic [3:0]           bright;
  logic                 raw_mode;
  logic [7:0]           raw_seg [NDIGITS];

  logic [31:0]      offset;
  logic             in_range;
  logic [31:0]      rdata;
  logic             tick;
  logic [3:0]       subtick;
  logic [DIG_W-1:0] digit;
  logic [3:0]       cur_nibble;
  logic [7:0]       seg_next;
  logic [NDIGITS-1:0] an_next;

  assign offset   = addr - 32'(BASE);
  assign in_range = (addr >= 32'(BASE)) && (addr < 32'(BASE + SIZE));

  seg7_prescale #(
    .SCAN_DIV(SCAN_DIV)
  ) u_prescale (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Register file: bus writes land at the edge, excess data bits are dropped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits   <= '0;
      dp       <= '0;
      blank    <= '0;
      bright   <= 4'hF;
      raw_mode <= 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
        raw_seg[i] <= 8'h00;
      end
    end else if (enable && rw && in_range) begin
      if (offset == REG_DIGITS) begin
        digits <= data[4*NDIGITS-1:0];
      end
      if (offset == REG_DP) begin
        dp <= data[NDIGITS-1:0];
      end
      if (offset == REG_CTRL) begin
        blank    <= data[NDIGITS-1:0];
        bright   <= data[NDIGITS+CTRL_BRIGHT_POS +: CTRL_BRIGHT_W];
        raw_mode <= data[NDIGITS+CTRL_RAW_POS];
      end
      for (int i = 0; i < NDIGITS; i++) begin
        if (offset == REG_RAW0 + 32'(i)) begin
          raw_seg[i] <= data[7:0];
        end
      end
    end
  end

  // Readback mux: zero-extended register contents, zero outside the block
  always_comb begin
    rdata = 32'h0;
    if (in_range) begin
      if (offset == REG_DIGITS) begin
        rdata[4*NDIGITS-1:0] = digits;
      end
      if (offset == REG_DP) begin
        rdata[NDIGITS-1:0] = dp;
      end
      if (offset == REG_CTRL) begin
        rdata[NDIGITS+4:0] = {raw_mode, bright, blank};
      end
      for (int i = 0; i < NDIGITS; i++) begin
        if (offset == REG_RAW0 + 32'(i)) begin
          rdata[7:0] = raw_seg[i];
        end
      end
    end
  end

  // Read data register: sampled before any same-edge write, held when idle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= 32'h0;
    end else if (enable && !rw) begin
      q <= rdata;
    end
  end

  // Subtick within the slot and digit selection; a full subtick lap moves on a digit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      subtick <= 4'd0;
      digit   <= '0;
    end else if (tick) begin
      subtick <= subtick + 4'd1;
      if (subtick == 4'(SUBTICKS - 1)) begin
        if (digit == LAST_DIGIT) begin
          digit <= '0;
        end else begin
          digit <= digit + 1'b1;
        end
      end
    end
  end

  // Next segment/anode pattern; subtick 0 stays dark so the previous digit never ghosts
  always_comb begin
    cur_nibble = digits[{digit, 2'b00} +: 4];
    if (raw_mode) begin
      seg_next = ~raw_seg[digit];
    end else begin
      seg_next = ~{dp[digit], hex2seg(cur_nibble)};
    end
    an_next = '1;
    if (!blank[digit] && (subtick != 4'd0) && (subtick <= bright)) begin
      an_next[digit] = 1'b0;
    end
  end

  // Output registers: one cycle behind the counters and register contents
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg <= 8'hFF;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a time-based behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_seg7_scan;

  localparam int N        = 4;
  localparam int BASE     = 16;
  localparam int SCAN_DIV = 2;
  localparam int SIZE     = 3 + N;
  localparam int ROTATION = SCAN_DIV * 16 * N;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         rw = 1'b0;
  logic [31:0]  addr = 32'h0;
  logic [31:0]  data = 32'h0;
  logic [31:0]  q;
  logic [7:0]   seg;
  logic [N-1:0] an;

  int compared = 0;
  int mismatched = 0;

  seg7_scan #(
    .NDIGITS (N),
    .BASE    (BASE),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .rw     (rw),
    .addr   (addr),
    .data   (data),
    .q      (q),
    .seg    (seg),
    .an     (an)
  );

  always #5 clk = ~clk;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [3:0]   m_digits [N];
  logic         m_dp [N];
  logic         m_blank [N];
  int           m_bright;
  logic         m_raw;
  logic [7:0]   m_rawseg [N];
  int           cyc;
  bit           model_valid = 1'b0;
  logic [7:0]   exp_seg;
  logic [N-1:0] exp_an;
  logic [31:0]  exp_q;
  int           ticks, sub, d, off;
  bit           hit;
  int           low_cnt [N];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int o);
    logic [31:0] v;
    v = 32'h0;
    case (o)
      0: for (int i = 0; i < N; i++) v[4*i +: 4] = m_digits[i];
      1: for (int i = 0; i < N; i++) v[i] = m_dp[i];
      2: begin
        for (int i = 0; i < N; i++) v[i] = m_blank[i];
        v[N +: 4] = 4'(m_bright);
        v[N+4]    = m_raw;
      end
      default: v[7:0] = m_rawseg[o-3];
    endcase
    return v;
  endfunction

  // Reference model: scan position derived from elapsed cycles since reset
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_digits[i] = 4'h0;
        m_dp[i]     = 1'b0;
        m_blank[i]  = 1'b0;
        m_rawseg[i] = 8'h00;
      end
      m_bright    = 15;
      m_raw       = 1'b0;
      cyc         = 0;
      exp_seg     = 8'hFF;
      exp_an      = '1;
      exp_q       = 32'h0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      ticks = cyc / SCAN_DIV;
      sub   = ticks % 16;
      d     = (ticks / 16) % N;
      exp_an = '1;
      if (!m_blank[d] && sub >= 1 && sub <= m_bright) exp_an[d] = 1'b0;
      exp_seg = m_raw ? ~m_rawseg[d] : ~{m_dp[d], font[m_digits[d]]};
      cyc++;
      hit = (addr >= 32'(BASE)) && (addr < 32'(BASE + SIZE));
      off = int'(addr) - BASE;
      if (enable && !rw) exp_q = hit ? model_read(off) : 32'h0;
      if (enable && rw && hit) begin
        case (off)
          0: for (int i = 0; i < N; i++) m_digits[i] = data[4*i +: 4];
          1: for (int i = 0; i < N; i++) m_dp[i] = data[i];
          2: begin
            for (int i = 0; i < N; i++) m_blank[i] = data[i];
            m_bright = int'(data[N +: 4]);
            m_raw    = data[N+4];
          end
          default: m_rawseg[off-3] = data[7:0];
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("seg", 32'(seg), 32'(exp_seg));
      checkOutput("an", 32'(an), 32'(exp_an));
      checkOutput("q", q, exp_q);
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    enable = 1'b1; rw = 1'b1; addr = a; data = v;
    @(negedge clk);
    enable = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] expected);
    enable = 1'b1; rw = 1'b0; addr = a;
    @(negedge clk);
    enable = 1'b0;
    checkOutput(name, q, expected);
  endtask

  task automatic wait_an(input string name, input logic [N-1:0] target,
                         input logic [N-1:0] prev, input int limit);
    int n;
    n = 0;
    while (an !== target && n < limit) begin
      if (an !== '1 && an !== prev) checkOutput({name, "_order"}, 32'(an), 32'(target));
      @(negedge clk);
      n++;
    end
    if (an !== target) checkOutput({name, "_timeout"}, 32'(an), 32'(target));
  endtask

  task automatic measure_duty(input int cycles);
    for (int i = 0; i < N; i++) low_cnt[i] = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) if (!an[i]) low_cnt[i]++;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      reset_n = ($urandom_range(0, 699) != 0);
      enable  = ($urandom_range(0, 3) == 0);
      rw      = $urandom_range(0, 1) == 1;
      addr    = 32'(BASE - 2 + int'($urandom_range(0, SIZE + 3)));
      data    = $urandom;
      @(negedge clk);
    end
    reset_n = 1'b1; enable = 1'b0; rw = 1'b0;
  endtask

  logic [N-1:0] order_an  [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
  logic [7:0]   order_seg [5] = '{8'h00, 8'hC0, 8'hA4, 8'hF9, 8'h00};

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_seg", 32'(seg), 32'h0000_00FF);
    checkOutput("reset_an", 32'(an), 32'h0000_000F);
    checkOutput("reset_q", q, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read("ctrl_reset", 32'(BASE + 2), 32'h0000_00F0);

    bus_write(32'(BASE), 32'h0000_1208);
    bus_write(32'(BASE + 1), 32'h0000_0001);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      wait_an("scan", order_an[k], (k == 0) ? 4'hF : order_an[k-1], 4 * ROTATION);
      checkOutput("scan_seg", 32'(seg), 32'(order_seg[k]));
    end

    bus_write(32'(BASE + 2), 32'h0000_0030);
    repeat (4) @(negedge clk);
    measure_duty(ROTATION);
    for (int i = 0; i < N; i++) checkOutput("duty_bright3", 32'(low_cnt[i]), 32'd6);

    bus_write(32'(BASE + 2), 32'h0000_0000);
    repeat (4) @(negedge clk);
    measure_duty(ROTATION);
    for (int i = 0; i < N; i++) checkOutput("duty_bright0", 32'(low_cnt[i]), 32'd0);

    bus_write(32'(BASE + 2), 32'h0000_00F4);
    repeat (4) @(negedge clk);
    measure_duty(ROTATION);
    checkOutput("blank_an0", 32'(low_cnt[0]), 32'd30);
    checkOutput("blank_an1", 32'(low_cnt[1]), 32'd30);
    checkOutput("blank_an2", 32'(low_cnt[2]), 32'd0);
    checkOutput("blank_an3", 32'(low_cnt[3]), 32'd30);

    bus_write(32'(BASE + 4), 32'h0000_0076);
    bus_write(32'(BASE + 2), 32'h0000_01F0);
    repeat (2) @(negedge clk);
    wait_an("raw", 4'hD, 4'hE, 4 * ROTATION);
    checkOutput("raw_seg1", 32'(seg), 32'h0000_0089);

    bus_write(32'd23, 32'hFFFF_FFFF);
    bus_read("oor_read", 32'd23, 32'h0);
    bus_read("oor_ctrl", 32'(BASE + 2), 32'h0000_01F0);
    bus_read("oor_raw1", 32'(BASE + 4), 32'h0000_0076);
    bus_read("oor_digits", 32'(BASE), 32'h0000_1208);

    wait_an("midslot", 4'hB, 4'hD, 4 * ROTATION);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_an", 32'(an), 32'h0000_000F);
    checkOutput("midreset_seg", 32'(seg), 32'h0000_00FF);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("restart_an", 32'(an), 32'h0000_000E);
    checkOutput("restart_seg", 32'(seg), 32'h0000_00C0);

    applyStimulus(4000);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
